// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit: operands and opcode in, status and result out.
// div_by_zero exists only when MULDIV_DIV0_FLAG_EN is defined.
interface mul_div_unit_if;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div_by_zero;

  modport master (output start, opcode, A, B,
                  input  busy, done, hi_out, lo_out, div_by_zero);
  modport slave  (input  start, opcode, A, B,
                  output busy, done, hi_out, lo_out, div_by_zero);
`else
  modport master (output start, opcode, A, B,
                  input  busy, done, hi_out, lo_out);
  modport slave  (input  start, opcode, A, B,
                  output busy, done, hi_out, lo_out);
`endif
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (magnitude restoring), 32 cycles/op.
// MULDIV_DIV0_FLAG_EN: divide-by-zero short-circuits to a 1-cycle completion with a div_by_zero flag.
module mul_div_unit (
  input  logic          clock,
  input  logic          clear,
  mul_div_unit_if.slave bus
);
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  typedef struct packed {
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [5:0]  cnt;
  logic [32:0] acc;
  logic [31:0] q;
  logic        q_m1;
  logic [31:0] m;
  logic [31:0] hi_r, lo_r;
  logic        busy_c, done_c;

  logic        op_valid, op_div, accept, fast_dz;
  logic [31:0] abs_a, abs_b;

  assign op_valid = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
  assign op_div   = (bus.opcode == OP_DIV);
  assign accept   = bus.start && op_valid && (state != RUN);
  assign abs_a    = bus.A[31] ? -bus.A : bus.A;
  assign abs_b    = bus.B[31] ? -bus.B : bus.B;

`ifdef MULDIV_DIV0_FLAG_EN
  logic dz_r;
  assign fast_dz         = accept && op_div && (bus.B == 32'd0);
  assign bus.div_by_zero = dz_r;
`else
  assign fast_dz = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: state_nxt = accept ? (fast_dz ? FINISH : RUN) : IDLE;
      RUN:          if (cnt == LAST_ITER) state_nxt = FINISH;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == RUN);
    done_c = (state == FINISH);
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;

  // ---------------- one iteration ----------------
  logic [32:0] booth_sum;
  logic [32:0] div_r;
  logic [33:0] div_trial;
  logic        div_ge;
  logic [32:0] acc_nxt;
  logic [31:0] q_nxt;
  logic        m1_nxt;

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + {m[31], m};
      2'b10:   booth_sum = acc - {m[31], m};
      default: booth_sum = acc;
    endcase
    // Partial remainder is always below the divisor, so the shifted value fits in 33 bits.
    div_r     = {acc[31:0], q[31]};
    div_trial = {1'b0, div_r} - {2'b00, m};
    div_ge    = ~div_trial[33];
    if (req.is_div) begin
      acc_nxt = div_ge ? div_trial[32:0] : div_r;
      q_nxt   = {q[30:0], div_ge};
      m1_nxt  = q_m1;
    end else begin
      acc_nxt = {booth_sum[32], booth_sum[32:1]};
      q_nxt   = {booth_sum[0], q[31:1]};
      m1_nxt  = q[0];
    end
  end

  // ---------------- final result ----------------
  logic [31:0] quo_s, rem_s, res_hi, res_lo;

  always_comb begin
    quo_s = (req.a_neg ^ req.b_neg) ? -q_nxt : q_nxt;
    rem_s = req.a_neg ? -acc_nxt[31:0] : acc_nxt[31:0];
    if (!req.is_div) begin
      res_hi = acc_nxt[31:0];
      res_lo = q_nxt;
    end else if (req.b_zero) begin
      res_hi = req.a;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt  <= '0;
      acc  <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      m    <= '0;
      req  <= '0;
      hi_r <= '0;
      lo_r <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
      dz_r <= 1'b0;
`endif
    end else if (accept) begin
      cnt  <= '0;
      acc  <= '0;
      q_m1 <= 1'b0;
      req  <= '{is_div: op_div, a_neg: bus.A[31], b_neg: bus.B[31],
                b_zero: (bus.B == 32'd0), a: bus.A};
      q    <= op_div ? abs_a : bus.A;
      m    <= op_div ? abs_b : bus.B;
`ifdef MULDIV_DIV0_FLAG_EN
      dz_r <= fast_dz;
      if (fast_dz) begin
        hi_r <= bus.A;
        lo_r <= 32'hFFFF_FFFF;
      end
`endif
    end else if (state == RUN) begin
      cnt  <= cnt + 6'd1;
      acc  <= acc_nxt;
      q    <= q_nxt;
      q_m1 <= m1_nxt;
      if (cnt == LAST_ITER) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit: driver pushes expected results from a plain
// arithmetic model, a negedge monitor checks busy every cycle and pops/compares on done.
module tb_mul_div_unit;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  mul_div_unit_if bus ();
  mul_div_unit dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        fast;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi = '0, last_lo = '0;
  logic        last_fast = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int c);
    exp_t   e;
    longint pa, pb, p;
    int     sa, sbv;
    e.dz = 1'b0;
    e.fast = 1'b0;
    if (op == OP_MUL) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
`ifdef MULDIV_DIV0_FLAG_EN
      e.dz = 1'b1;
      e.fast = 1'b1;
`endif
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'd0;
      e.lo = 32'h8000_0000;
    end else begin
      sa  = $signed(a);
      sbv = $signed(b);
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end
    e.cyc = c + (e.fast ? 1 : 33);
    return e;
  endfunction

  // Called at negedge+1; the following posedge is the acceptance edge (end of cycle 0).
  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.opcode = op;
    bus.A = a;
    bus.B = b;
    e = model(op, a, b, cyc);
    sb.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    last_fast = e.fast;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.opcode = 5'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.done !== 1'b1 && n < 40);
    #1;
    if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy expectation every cycle, result/latency/flag compare on each done pulse.
  always @(negedge clock) begin
    exp_t e;
    logic exp_busy;
    if (clear === 1'b0) begin
      exp_busy = (sb.size() > 0) && !sb[0].fast && (cyc >= sb[0].cyc - 32) && (cyc < sb[0].cyc);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(cyc), 32'(e.cyc));
          check("hi_out", bus.hi_out, e.hi);
          check("lo_out", bus.lo_out, e.lo);
`ifdef MULDIV_DIV0_FLAG_EN
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
`endif
        end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        check("done_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_hi"}, bus.hi_out, 32'd0);
    check({tag, "_lo"}, bus.lo_out, 32'd0);
`ifdef MULDIV_DIV0_FLAG_EN
    check({tag, "_dz"}, 32'(bus.div_by_zero), 32'd0);
`endif
  endtask

  logic [4:0]  d_op[5] = '{OP_MUL, OP_MUL, OP_DIV, OP_DIV, OP_DIV};
  logic [31:0] d_a[5]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
  logic [31:0] d_b[5]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0};

  initial begin
    clear = 1'b1;
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    #1 clear = 1'b0;
    @(negedge clock); #1;

    // Directed corner cases, back-to-back: each next start lands in the previous FINISH cycle.
    for (int i = 0; i < 5; i++) begin
      drive_op(d_op[i], d_a[i], d_b[i]);
      wait_done();
    end

    // Invalid opcode with start: ignored, results hold.
    @(negedge clock); #1;
    bus.start = 1'b1;
    bus.opcode = 5'($urandom_range(0, 14));
    bus.A = $urandom;
    bus.B = $urandom;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("inv_hold_hi", bus.hi_out, last_hi);
    check("inv_hold_lo", bus.lo_out, last_lo);
    #1;

    // Mul aborted by clear in cycle 10; start presented together with clear must lose.
    drive_op(OP_MUL, 32'd3, 32'd4);
    repeat (10) @(negedge clock);
    #1;
    clear = 1'b1;
    sb.delete();
    bus.start = 1'b1;
    bus.opcode = OP_DIV;
    bus.A = 32'd9;
    bus.B = 32'd3;
    @(posedge clock); #1;
    clear = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    check_zero("abort");
    repeat (3) @(negedge clock);
    check_zero("abort_idle");
    #1;
    drive_op(OP_DIV, 32'd100, 32'd7);
    wait_done();

    // Random traffic, occasionally poking start while RUN (must be ignored).
    for (int i = 0; i < 30; i++) begin
      drive_op($urandom_range(0, 1) ? OP_MUL : OP_DIV, pick_operand(), pick_operand());
      if (!last_fast && $urandom_range(0, 1)) begin
        repeat ($urandom_range(1, 28)) @(negedge clock);
        #1;
        bus.start = 1'b1;
        bus.opcode = $urandom_range(0, 1) ? OP_MUL : OP_DIV;
        @(posedge clock); #1;
        bus.start = 1'b0;
      end
      wait_done();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clock);
        #1;
      end
    end

    repeat (4) @(negedge clock);
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001: clock  input  1  sole clock; all state changes on rising edge.
REQ-002: clear  input  1  reset, synchronous, active-high.
REQ-003: start  input  1  request pulse; sampled each rising edge.
REQ-004: opcode  input  5  operation select; 5'b01111 = Mul, 5'b10000 = Div, all other codes ignored.
REQ-005: A  input  32  multiplicand / dividend, two's complement.
REQ-006: B  input  32  multiplier / divisor, two's complement.
REQ-007: busy  output  1  high while an operation is in progress.
REQ-008: done  output  1  one-cycle pulse; result valid.
REQ-009: hi_out  output  32  Mul: product[63:32]; Div: remainder. This feeds the ALU Mul_HI/Div_HI path.
REQ-010: lo_out  output  32  Mul: product[31:0]; Div: quotient. This feeds the ALU Mul_LO/Div_LO path.
REQ-011: div_by_zero  output  1  present only when MULDIV_DIV0_FLAG_EN is defined (see REQ-028).

Function
REQ-012: The FSM SHALL have three states: IDLE, RUN, FINISH.
- IDLE -> RUN on start=1 with a valid opcode.
- RUN -> FINISH after the 32nd iteration.
- FINISH -> IDLE unconditionally.
REQ-013: On acceptance (cycle 0), A, B and the opcode SHALL be latched internally; later changes to A, B and opcode SHALL have no effect on the operation.
REQ-014: busy SHALL be 1 in cycles 1..32 and 0 otherwise.
REQ-015: done SHALL be 1 in cycle 33 only; hi_out and lo_out SHALL be updated in cycle 33.
REQ-016: hi_out and lo_out SHALL hold their last value until the next completion or clear.
REQ-017: start SHALL be ignored while in RUN.
REQ-018: start in FINISH SHALL be accepted, with that cycle counted as cycle 0 of the new operation.
REQ-019: start with an invalid opcode SHALL be ignored; the FSM stays in IDLE and the outputs are unchanged.
REQ-020: Mul SHALL compute the signed 32x32 -> 64-bit product using radix-2 Booth recoding, one iteration per cycle, with a 6-bit iteration counter.
REQ-021: Div SHALL compute signed division by magnitude restoring division, one quotient bit per cycle, followed by sign correction:
- quotient truncates toward zero;
- remainder takes the sign of the dividend;
- A = B*lo_out + hi_out SHALL hold exactly.
REQ-022: Div of 0x80000000 by 0xFFFFFFFF SHALL produce lo_out = 0x80000000 and hi_out = 0x00000000 (wraps, no trap).
REQ-023: Div with B = 0 SHALL produce lo_out = 0xFFFFFFFF and hi_out = A.

Reset
REQ-024: While clear=1, the FSM SHALL be forced to IDLE and busy, done, hi_out, lo_out and div_by_zero SHALL be 0 at the next edge.
REQ-025: clear SHALL take priority over start.
REQ-026: clear asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027: The first start accepted after clear deasserts SHALL run with full normal latency.

Configuration
REQ-028: With MULDIV_DIV0_FLAG_EN defined, behaviour SHALL be:
- Div with latched B = 0 goes IDLE -> FINISH directly (busy stays 0);
- done pulses in cycle 1;
- the result is per REQ-023;
- div_by_zero = 1 coincident with done and holds until the next accepted start or clear.
REQ-029: Without MULDIV_DIV0_FLAG_EN, the div_by_zero port SHALL not exist, and Div by zero SHALL take the normal 33-cycle latency with the result per REQ-023.

Verification
REQ-030: Mul A=7, B=-3 (0xFFFFFFFD) -> done in cycle 33 only; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high cycles 1..32.
REQ-031: Mul A=B=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
REQ-032: Div A=-7, B=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
REQ-033: Div A=0x80000000, B=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-034: Div A=5, B=0:
- with MULDIV_DIV0_FLAG_EN: done and div_by_zero in cycle 1, lo_out=0xFFFFFFFF, hi_out=5;
- without it: done in cycle 33 with the same values.
REQ-035: Mul 3x4 with clear pulsed in cycle 10 -> no done pulse; all outputs 0; a following Div 100/7 gives lo_out=14, hi_out=2 in cycle 33 relative to its own start.
